// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO that feeds the pipelined CORDIC sin/cos generator.
// It supports a shadowed run-time config, a linear sawtooth/triangle frequency sweep and a latency-matched valid.
module nco_phase_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int CORDIC_LAT = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  sync_clr,
    input  logic                  cfg_wr,
    input  logic [ACC_WIDTH-1:0]  cfg_ftw,
    input  logic [DATA_WIDTH-1:0] cfg_pow,
    input  logic [ACC_WIDTH-1:0]  cfg_step,
    input  logic [15:0]           cfg_len,
    input  logic                  cfg_tri,
    output logic                  cfg_ack,
    output logic [DATA_WIDTH-1:0] phase_out,
    output logic                  phase_vld,
    output logic                  out_vld
);

    typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN} state_t;

    // Wrapping 2*pi phase addition of the accumulator top bits and the offset.
    function automatic logic [DATA_WIDTH-1:0] phase_wrap_add(
        input logic [ACC_WIDTH-1:0]  acc,
        input logic [DATA_WIDTH-1:0] pow
    );
        return acc[ACC_WIDTH-1 -: DATA_WIDTH] + pow;
    endfunction

    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ACC_WIDTH-1:0]  ftw_act_q, ftw_act_d;
    logic [ACC_WIDTH-1:0]  ftw_base_q, ftw_base_d;
    logic [ACC_WIDTH-1:0]  step_act_q, step_act_d;
    logic [15:0]           len_act_q, len_act_d;
    logic                  tri_act_q, tri_act_d;
    logic [DATA_WIDTH-1:0] pow_act_q, pow_act_d;
    logic [ACC_WIDTH-1:0]  sh_ftw_q, sh_ftw_d;
    logic [DATA_WIDTH-1:0] sh_pow_q, sh_pow_d;
    logic [ACC_WIDTH-1:0]  sh_step_q, sh_step_d;
    logic [15:0]           sh_len_q, sh_len_d;
    logic                  sh_tri_q, sh_tri_d;
    logic                  pending_q, pending_d;
    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] phase_out_q, phase_out_d;
    logic                  phase_vld_q, phase_vld_d;
    logic [CORDIC_LAT-2:0] vld_sr_q, vld_sr_d;
    logic                  out_vld_q, out_vld_d;
    logic                  cfg_ack_q, cfg_ack_d;

    logic ramp_end;
    assign ramp_end = (cnt_q == len_act_q - 16'd1);

    always_comb begin
        acc_d       = acc_q;
        ftw_act_d   = ftw_act_q;
        ftw_base_d  = ftw_base_q;
        step_act_d  = step_act_q;
        len_act_d   = len_act_q;
        tri_act_d   = tri_act_q;
        pow_act_d   = pow_act_q;
        sh_ftw_d    = sh_ftw_q;
        sh_pow_d    = sh_pow_q;
        sh_step_d   = sh_step_q;
        sh_len_d    = sh_len_q;
        sh_tri_d    = sh_tri_q;
        pending_d   = pending_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_out_d = phase_out_q;
        phase_vld_d = phase_vld_q;
        vld_sr_d    = vld_sr_q;
        out_vld_d   = out_vld_q;
        cfg_ack_d   = 1'b0;

        if (sync_clr) begin
            acc_d       = '0;
            phase_out_d = pow_act_q;
            cnt_d       = '0;
            ftw_act_d   = ftw_base_q;
            state_d     = (len_act_q != 16'd0) ? ST_UP : ST_IDLE;
            phase_vld_d = 1'b0;
            vld_sr_d    = '0;
            out_vld_d   = 1'b0;
        end else if (ena) begin
            // Output stage: phase uses the pre-update accumulator and offset.
            phase_out_d = phase_wrap_add(acc_q, pow_act_q);
            acc_d       = acc_q + ftw_act_q;
            phase_vld_d = 1'b1;
            vld_sr_d    = {vld_sr_q[CORDIC_LAT-3:0], 1'b1};
            out_vld_d   = vld_sr_q[CORDIC_LAT-2];
            if (pending_q) begin
                // Apply is phase-continuous: acc is not cleared.
                ftw_act_d  = sh_ftw_q;
                ftw_base_d = sh_ftw_q;
                pow_act_d  = sh_pow_q;
                step_act_d = sh_step_q;
                len_act_d  = sh_len_q;
                tri_act_d  = sh_tri_q;
                cnt_d      = '0;
                state_d    = (sh_len_q != 16'd0) ? ST_UP : ST_IDLE;
                pending_d  = 1'b0;
                cfg_ack_d  = 1'b1;
            end else begin
                case (state_q)
                    ST_UP: begin
                        if (ramp_end) begin
                            cnt_d = '0;
                            if (tri_act_q) begin
                                ftw_act_d = ftw_act_q + step_act_q;
                                state_d   = ST_DOWN;
                            end else begin
                                ftw_act_d = ftw_base_q;
                            end
                        end else begin
                            ftw_act_d = ftw_act_q + step_act_q;
                            cnt_d     = cnt_q + 16'd1;
                        end
                    end
                    ST_DOWN: begin
                        ftw_act_d = ftw_act_q - step_act_q;
                        if (ramp_end) begin
                            cnt_d   = '0;
                            state_d = ST_UP;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            phase_vld_d = 1'b0;
        end

        // A write on the apply edge re-arms pending with the new values.
        if (cfg_wr) begin
            sh_ftw_d  = cfg_ftw;
            sh_pow_d  = cfg_pow;
            sh_step_d = cfg_step;
            sh_len_d  = cfg_len;
            sh_tri_d  = cfg_tri;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            ftw_act_q   <= '0;
            ftw_base_q  <= '0;
            step_act_q  <= '0;
            len_act_q   <= '0;
            tri_act_q   <= 1'b0;
            pow_act_q   <= '0;
            sh_ftw_q    <= '0;
            sh_pow_q    <= '0;
            sh_step_q   <= '0;
            sh_len_q    <= '0;
            sh_tri_q    <= 1'b0;
            pending_q   <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            phase_out_q <= '0;
            phase_vld_q <= 1'b0;
            vld_sr_q    <= '0;
            out_vld_q   <= 1'b0;
            cfg_ack_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ftw_act_q   <= ftw_act_d;
            ftw_base_q  <= ftw_base_d;
            step_act_q  <= step_act_d;
            len_act_q   <= len_act_d;
            tri_act_q   <= tri_act_d;
            pow_act_q   <= pow_act_d;
            sh_ftw_q    <= sh_ftw_d;
            sh_pow_q    <= sh_pow_d;
            sh_step_q   <= sh_step_d;
            sh_len_q    <= sh_len_d;
            sh_tri_q    <= sh_tri_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_out_q <= phase_out_d;
            phase_vld_q <= phase_vld_d;
            vld_sr_q    <= vld_sr_d;
            out_vld_q   <= out_vld_d;
            cfg_ack_q   <= cfg_ack_d;
        end
    end

    assign cfg_ack   = cfg_ack_q;
    assign phase_out = phase_out_q;
    assign phase_vld = phase_vld_q;
    assign out_vld   = out_vld_q;

endmodule
